// File: rtl/vc_trace_line_buf_pkg.sv
// Shared trace definitions: the line-buffer FSM states, the line terminator
// character and the default line width (512 characters, matching the existing
// trace width).
package vc_trace_line_buf_pkg;

   localparam int unsigned NCHARS_DEFAULT = 512;
   localparam logic [7:0]  CHAR_NEWLINE   = 8'h0A;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Address width for a storage array of the given depth (at least 1 bit).
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/vc_trace_line_ram.sv
// Character storage for one trace line.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - character to store
//   i_raddr  - read address
//   o_rdata  - character at i_raddr (combinational read)
// Contents are not reset.
module vc_trace_line_ram
   import vc_trace_line_buf_pkg::*;
#(
   parameter int unsigned DEPTH = NCHARS_DEFAULT,
   parameter int unsigned AW    = addr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // Single write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vc_trace_line_buf.sv
// Trace line buffer: collects one line of ASCII trace characters, then replays
// it downstream terminated by a newline. Characters beyond NCHARS are dropped
// and flagged on ovf until that line has been fully drained.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   in_val/in_rdy/in_msg     - upstream character handshake
//   out_val/out_rdy/out_msg  - downstream character handshake
//   out_last            - marks the newline that ends each emitted line
//   ovf                 - current line was truncated
//   line_count          - lines fully drained since reset (wraps)
module vc_trace_line_buf
   import vc_trace_line_buf_pkg::*;
#(
   parameter int unsigned NCHARS = NCHARS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_val,
   output logic        in_rdy,
   input  logic [7:0]  in_msg,
   output logic        out_val,
   input  logic        out_rdy,
   output logic [7:0]  out_msg,
   output logic        out_last,
   output logic        ovf,
   output logic [31:0] line_count
);

   localparam int unsigned CW = $clog2(NCHARS + 1);
   localparam int unsigned AW = addr_width(NCHARS);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [CW-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic          r_ovf, w_ovf_nxt;
   logic [31:0]   r_line_count, w_line_count_nxt;

   logic          w_in_fire;
   logic          w_out_fire;
   logic          w_is_nl;
   logic          w_full;
   logic          w_at_end;
   logic          w_we;
   logic [7:0]    w_rdata;

   // Handshake and output view; all derived from registered state only.
   assign in_rdy     = (r_state == FILL);
   assign out_val    = (r_state == DRAIN);
   assign w_in_fire  = in_val & in_rdy;
   assign w_out_fire = out_val & out_rdy;
   assign w_is_nl    = (in_msg == CHAR_NEWLINE);
   assign w_full     = (r_count == CW'(NCHARS));
   // Once every stored character has gone out, the next character is the
   // synthesized newline; this also covers the empty-line case.
   assign w_at_end   = (r_rd_ptr == r_count);
   assign out_last   = out_val & w_at_end;
   assign out_msg    = w_at_end ? CHAR_NEWLINE : w_rdata;
   assign ovf        = r_ovf;
   assign line_count = r_line_count;

   assign w_we = w_in_fire & ~w_is_nl & ~w_full;

   vc_trace_line_ram #(
      .DEPTH (NCHARS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (AW'(r_count)),
      .i_wdata (in_msg),
      .i_raddr (AW'(r_rd_ptr)),
      .o_rdata (w_rdata)
   );

   // Next-state logic for the fill/drain FSM and its counters.
   always_comb begin
      w_state_nxt      = r_state;
      w_count_nxt      = r_count;
      w_rd_ptr_nxt     = r_rd_ptr;
      w_ovf_nxt        = r_ovf;
      w_line_count_nxt = r_line_count;

      case (r_state)
         FILL: begin
            if (w_in_fire) begin
               if (w_is_nl) begin
                  w_rd_ptr_nxt = '0;
                  w_state_nxt  = DRAIN;
               end else if (w_full) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_count_nxt = r_count + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (w_out_fire) begin
               if (w_at_end) begin
                  w_count_nxt      = '0;
                  w_rd_ptr_nxt     = '0;
                  w_ovf_nxt        = 1'b0;
                  w_line_count_nxt = r_line_count + 32'd1;
                  w_state_nxt      = FILL;
               end else begin
                  w_rd_ptr_nxt = r_rd_ptr + CW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = FILL;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= FILL;
         r_count      <= '0;
         r_rd_ptr     <= '0;
         r_ovf        <= 1'b0;
         r_line_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_ovf        <= w_ovf_nxt;
         r_line_count <= w_line_count_nxt;
      end
   end

endmodule

// File: tb/tb_vc_trace_line_buf.sv
// Self-checking bench for vc_trace_line_buf: directed lines plus randomized
// traffic, checked every cycle against a queue-based line model.
module tb_vc_trace_line_buf;

   localparam int unsigned NCH = 4;
   localparam logic [7:0]  NL  = 8'h0A;

   logic        clk;
   logic        reset;
   logic        in_val;
   logic        in_rdy;
   logic [7:0]  in_msg;
   logic        out_val;
   logic        out_rdy;
   logic [7:0]  out_msg;
   logic        out_last;
   logic        ovf;
   logic [31:0] line_count;

   vc_trace_line_buf #(.NCHARS(NCH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_val     (in_val),
      .in_rdy     (in_rdy),
      .in_msg     (in_msg),
      .out_val    (out_val),
      .out_rdy    (out_rdy),
      .out_msg    (out_msg),
      .out_last   (out_last),
      .ovf        (ovf),
      .line_count (line_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: characters waiting upstream, the line being collected (already
   // truncated to NCH), and the characters still owed downstream.
   logic [7:0]  src_q [$];
   logic [7:0]  line_q [$];
   logic [7:0]  exp_q [$];
   bit          m_drain = 1'b0;
   bit          m_ovf   = 1'b0;
   logic [31:0] m_lines = '0;

   int in_mode  = 0;   // 0: in_val whenever data is queued, 1: random
   int out_mode = 0;   // 0: always ready, 1: random, 2: 1,0,0 pattern
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
   endtask

   task automatic push_rand_line();
      int len;
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom_range(32, 126)));
      src_q.push_back(NL);
   endtask

   // One clock: compare outputs with the model, drive the next inputs, then
   // advance the model by the transfers those inputs cause at the next edge.
   task automatic step();
      logic [7:0] c;
      @(negedge clk);
      check_eq("in_rdy", 32'(in_rdy), 32'(!m_drain));
      check_eq("out_val", 32'(out_val), 32'(m_drain));
      check_eq("ovf", 32'(ovf), 32'(m_ovf));
      check_eq("line_count", line_count, m_lines);
      if (m_drain) begin
         check_eq("out_msg", 32'(out_msg), 32'(exp_q[0]));
         check_eq("out_last", 32'(out_last), 32'(exp_q.size() == 1));
      end else begin
         check_eq("out_last_idle", 32'(out_last), 32'(0));
      end

      in_val = (src_q.size() != 0) && (in_mode == 0 || $urandom_range(0, 99) < 70);
      in_msg = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
      case (out_mode)
         0:       out_rdy = 1'b1;
         1:       out_rdy = ($urandom_range(0, 99) < 60);
         default: out_rdy = (cyc % 3 == 0);
      endcase

      if (!m_drain && in_val) begin
         c = src_q.pop_front();
         if (c == NL) begin
            exp_q = line_q;
            exp_q.push_back(NL);
            line_q.delete();
            m_drain = 1'b1;
         end else if (line_q.size() < NCH) begin
            line_q.push_back(c);
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_drain && out_rdy) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) begin
            m_drain = 1'b0;
            m_ovf   = 1'b0;
            m_lines = m_lines + 32'd1;
         end
      end
      cyc++;
   endtask

   task automatic run_until_idle();
      int n;
      n = 0;
      while ((src_q.size() != 0 || m_drain) && n < 2000) begin
         step();
         n++;
      end
      step();
      check_eq("idle_reached", 32'(src_q.size()) + 32'(m_drain), 32'(0));
   endtask

   initial begin
      int n;
      reset   = 1'b0;
      in_val  = 1'b0;
      in_msg  = 8'h00;
      out_rdy = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_rdy", 32'(in_rdy), 32'(1));
      check_eq("rst_out_val", 32'(out_val), 32'(0));
      check_eq("rst_out_last", 32'(out_last), 32'(0));
      check_eq("rst_ovf", 32'(ovf), 32'(0));
      check_eq("rst_line_count", line_count, 32'(0));
      @(negedge clk);
      reset = 1'b1;

      // Basic line, empty line, truncated line.
      in_mode = 0; out_mode = 0;
      push_str("AB\n");
      run_until_idle();
      check_eq("ab_lines", line_count, 32'(1));
      push_str("\n");
      run_until_idle();
      check_eq("empty_lines", line_count, 32'(2));
      push_str("ABCDEF\n");
      run_until_idle();
      check_eq("ovf_cleared", 32'(ovf), 32'(0));

      // Downstream stalls in a fixed pattern.
      out_mode = 2;
      push_str("XYZ\n");
      run_until_idle();

      // Back-to-back lines with in_val held high.
      out_mode = 0;
      push_str("one\ntwo\nsix\n");
      run_until_idle();
      check_eq("b2b_lines", line_count, 32'(7));

      // Reset in the middle of draining "HELLO".
      push_str("HELLO\n");
      n = 0;
      while (!(m_drain && exp_q.size() == 4) && n < 100) begin
         step();
         n++;
      end
      check_eq("reach_E", 32'(exp_q.size()), 32'(4));
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_out_val", 32'(out_val), 32'(0));
      check_eq("arst_in_rdy", 32'(in_rdy), 32'(1));
      check_eq("arst_out_last", 32'(out_last), 32'(0));
      check_eq("arst_ovf", 32'(ovf), 32'(0));
      check_eq("arst_line_count", line_count, 32'(0));
      src_q.delete(); line_q.delete(); exp_q.delete();
      m_drain = 1'b0; m_ovf = 1'b0; m_lines = '0;
      in_val  = 1'b0; out_rdy = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      push_str("Q\n");
      run_until_idle();
      check_eq("q_lines", line_count, 32'(1));

      // Randomized traffic.
      for (int k = 0; k < 30; k++) begin
         in_mode  = int'($urandom_range(0, 1));
         out_mode = int'($urandom_range(0, 2));
         push_rand_line();
         if ($urandom_range(0, 1) == 1) push_rand_line();
         run_until_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vc_trace_line_buf.md
VC_TRACE_LINE_BUF -- requirements
Module: vc_trace_line_buf

Interface
REQ-001 Parameter NCHARS, default 512: line buffer capacity in characters, excluding the terminating newline.
REQ-002 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port reset  input  1  reset; asynchronous and active-low.
REQ-004 Port in_val  input  1  upstream trace character valid.
REQ-005 Port in_rdy  output  1  block accepts a character this cycle.
REQ-006 Port in_msg  input  8  ASCII trace character; 8'h0A (newline) terminates a line.
REQ-007 Port out_val  output  1  output character valid.
REQ-008 Port out_rdy  input  1  downstream sink ready.
REQ-009 Port out_msg  output  8  output ASCII character.
REQ-010 Port out_last  output  1  high with the newline character that ends each emitted line.
REQ-011 Port ovf  output  1  the line currently in the buffer or being drained was truncated.
REQ-012 Port line_count  output  32  number of lines fully drained since reset.

Function
REQ-013 The block shall be an FSM with two states: FILL (the reset state) and DRAIN.
REQ-014 A transfer on either port shall occur only in a cycle where that port's val and rdy are both high at posedge clk.
REQ-015 FILL: in_rdy=1 and out_val=0.
REQ-016 FILL, non-newline transfer with count<NCHARS: write in_msg to buf[count], then count+=1.
REQ-017 FILL, non-newline transfer with count==NCHARS: drop the character, set ovf=1 (sticky for the current line), leave count unchanged.
REQ-018 FILL, newline transfer: do not store the newline, clear rd_ptr, go to DRAIN; the first output character shall be valid in the next cycle (1-cycle latency).
REQ-019 DRAIN: in_rdy=0; out_val=1; out_msg=buf[rd_ptr] while rd_ptr<count, otherwise 8'h0A with out_last=1.
REQ-020 DRAIN: each output transfer with rd_ptr<count shall increment rd_ptr.
REQ-021 DRAIN: the out_last transfer shall clear count, rd_ptr and ovf, increment line_count (wrapping modulo 2^32), and return the FSM to FILL.
REQ-022 Empty line (newline received with count==0): the block shall emit exactly one character, 8'h0A with out_last=1.
REQ-023 out_rdy=0 in DRAIN: out_msg, out_last and rd_ptr shall hold unchanged; there is no bubble on resume.
REQ-024 in_val while in DRAIN shall be ignored; the upstream holds its character because in_rdy=0.
REQ-025 count width shall be clog2(NCHARS+1); rd_ptr shall never exceed count.

Reset
REQ-026 Asserting reset (low) shall immediately force: state=FILL, count=0, rd_ptr=0, ovf=0, line_count=0, out_val=0, out_last=0, in_rdy=1.
REQ-027 Reset during DRAIN shall abandon the partial line; no further characters of that line shall be emitted.
REQ-028 Buffer contents need not be reset.
REQ-029 Deassertion shall be synchronized by the integrator; the block's first valid transfer is on the first posedge clk after deassertion.

Structure
REQ-030 The shared trace package shall hold the state enum (FILL, DRAIN), the newline constant 8'h0A and the default NCHARS=512, consistent with the existing 512-character trace width.
REQ-031 Character storage shall be one sub-module, vc_trace_line_ram: NCHARS x 8, 1 write port, combinational read port.
REQ-032 The FSM, counters and handshake logic shall reside in vc_trace_line_buf.

Verification
REQ-033 Send "AB\n" with out_rdy=1 -> out_msg 'A','B',0x0A on 3 consecutive cycles starting 1 cycle after the newline; out_last only on 0x0A; line_count=1.
REQ-034 Send "\n" alone -> a single 0x0A with out_last=1; line_count increments by 1.
REQ-035 NCHARS=4; send "ABCDEF\n" -> ovf=1 from the 'E' transfer onward; output "ABCD",0x0A; after the last transfer ovf=0.
REQ-036 Send "XYZ\n" with out_rdy toggling 1,0,0,1,... -> output "XYZ",0x0A with no loss or duplication; out_msg stable while out_rdy=0; in_rdy=0 throughout DRAIN.
REQ-037 Send "HELLO\n"; assert reset after 'E' is output -> all outputs at reset values asynchronously; next line "Q\n" emits only 'Q',0x0A.
REQ-038 Send 3 lines back-to-back with in_val held high -> newline-to-first-output latency of 1 cycle for each line; line_count=3.
